ace_snoop_responder: RTL and testbench

ACE_SNOOP_RESPONDER -- requirements
Module: ace_snoop_responder

---
 rtl/ace_pkg.sv | 94 +++++++++
 rtl/ace_snoop_responder.sv | 155 +++++++++++++++
 tb/tb_ace_snoop_responder.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ace_pkg.sv
// ACE snoop channel types, snoop opcodes, CR bit positions, line-update codes
// and the pure snoop-response / line-update decode used by the snoop responder.
package ace_pkg;

  localparam int unsigned AceAddrWidth = 64;
  localparam int unsigned AceDataWidth = 64;

  localparam logic [3:0] SnReadOnce           = 4'b0000;
  localparam logic [3:0] SnReadShared         = 4'b0001;
  localparam logic [3:0] SnReadClean          = 4'b0010;
  localparam logic [3:0] SnReadNotSharedDirty = 4'b0011;
  localparam logic [3:0] SnReadUnique         = 4'b0111;
  localparam logic [3:0] SnCleanShared        = 4'b1000;
  localparam logic [3:0] SnCleanInvalid       = 4'b1001;
  localparam logic [3:0] SnMakeInvalid        = 4'b1101;

  localparam int unsigned CrDataTransfer = 0;
  localparam int unsigned CrError        = 1;
  localparam int unsigned CrPassDirty    = 2;
  localparam int unsigned CrIsShared     = 3;
  localparam int unsigned CrWasUnique    = 4;

  localparam logic [1:0] UpdNone        = 2'd0;
  localparam logic [1:0] UpdSharedClean = 2'd1;
  localparam logic [1:0] UpdInvalid     = 2'd2;

  typedef struct packed {
    logic [AceAddrWidth-1:0] addr;
    logic [3:0]              snoop;
  } ace_ac_t;

  typedef logic [4:0] ace_cr_t;

  typedef struct packed {
    logic [AceDataWidth-1:0] data;
    logic                    last;
  } ace_cd_t;

  typedef struct packed {
    logic    ac_valid;
    ace_ac_t ac;
    logic    cr_ready;
    logic    cd_ready;
  } ace_snoop_req_t;

  typedef struct packed {
    logic    ac_ready;
    logic    cr_valid;
    ace_cr_t cr_resp;
    logic    cd_valid;
    ace_cd_t cd;
  } ace_snoop_resp_t;

  typedef struct packed {
    logic [4:0] cr_resp;
    logic [1:0] upd_op;
  } snoop_decode_t;

  // Miss or an opcode we do not serve answers all-zero and leaves the line alone.
  function automatic snoop_decode_t snoop_decode(input logic [3:0] snoop, input logic hit,
                                                 input logic dirty, input logic shared);
    snoop_decode_t res;
    logic is_read, is_clean, keeps_copy, supported, xfer;
    logic [1:0] upd;
    res        = '0;
    is_read    = 1'b0;
    is_clean   = 1'b0;
    keeps_copy = 1'b0;
    supported  = 1'b1;
    upd        = UpdNone;
    case (snoop)
      SnReadOnce:           begin is_read = 1'b1; keeps_copy = 1'b1; upd = UpdNone;        end
      SnReadShared,
      SnReadClean,
      SnReadNotSharedDirty: begin is_read = 1'b1; keeps_copy = 1'b1; upd = UpdSharedClean; end
      SnReadUnique:         begin is_read = 1'b1;                    upd = UpdInvalid;     end
      SnCleanShared:        begin is_clean = 1'b1; keeps_copy = 1'b1; upd = UpdSharedClean; end
      SnCleanInvalid:       begin is_clean = 1'b1;                    upd = UpdInvalid;     end
      SnMakeInvalid:        begin                                     upd = UpdInvalid;     end
      default:              supported = 1'b0;
    endcase
    xfer = is_read | (is_clean & dirty);
    if (hit && supported) begin
      res.cr_resp[CrDataTransfer] = xfer;
      res.cr_resp[CrError]        = 1'b0;
      res.cr_resp[CrPassDirty]    = dirty & xfer & (snoop != SnReadOnce);
      res.cr_resp[CrIsShared]     = keeps_copy;
      res.cr_resp[CrWasUnique]    = ~shared;
      res.upd_op                  = upd;
    end
    return res;
  endfunction

endpackage

// File: rtl/ace_snoop_responder.sv
// Serves one ACE snoop at a time: AC accept, tag lookup, CR, optional CD line beats, state update.
// AC-to-CR takes at least 3 cycles; every outbound request holds its payload until accepted.
module ace_snoop_responder
  import ace_pkg::*;
#(
  parameter int unsigned NumBeats  = 4,
  parameter int unsigned AddrWidth = 64,
  parameter type ac_chan_t    = ace_ac_t,
  parameter type cr_chan_t    = ace_cr_t,
  parameter type cd_chan_t    = ace_cd_t,
  parameter type snoop_req_t  = ace_snoop_req_t,
  parameter type snoop_resp_t = ace_snoop_resp_t
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  snoop_req_t                  snoop_req_i,
  output snoop_resp_t                 snoop_resp_o,
  output logic                        lu_valid_o,
  input  logic                        lu_ready_i,
  output logic [AddrWidth-1:0]        lu_addr_o,
  output logic [3:0]                  lu_snoop_o,
  input  logic                        lu_rsp_valid_i,
  input  logic                        lu_hit_i,
  input  logic                        lu_dirty_i,
  input  logic                        lu_shared_i,
  input  logic                        data_valid_i,
  output logic                        data_ready_o,
  input  logic [$bits(cd_chan_t)-2:0] data_i,
  output logic                        upd_valid_o,
  input  logic                        upd_ready_i,
  output logic [1:0]                  upd_op_o
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLookup  = 3'd1;
  localparam logic [2:0] StWaitRsp = 3'd2;
  localparam logic [2:0] StCr      = 3'd3;
  localparam logic [2:0] StCd      = 3'd4;
  localparam logic [2:0] StUpd     = 3'd5;

  localparam int unsigned BeatWidth = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(NumBeats - 1);

  logic [2:0]           state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [3:0]           snoop_q, snoop_d;
  logic [4:0]           cr_q, cr_d;
  logic [1:0]           upd_q, upd_d;
  logic [BeatWidth-1:0] beat_q, beat_d;

  ac_chan_t      ac;
  cr_chan_t      cr_resp;
  cd_chan_t      cd;
  snoop_decode_t dec;
  logic          ac_ready, ac_hs, cd_hs, last_beat;

  assign ac        = snoop_req_i.ac;
  assign dec       = snoop_decode(snoop_q, lu_hit_i, lu_dirty_i, lu_shared_i);
  // ac_ready is gated by rst_ni so the channel reads closed for the whole reset window.
  assign ac_ready  = (state_q == StIdle) && rst_ni;
  assign ac_hs     = snoop_req_i.ac_valid && ac_ready;
  assign cd_hs     = (state_q == StCd) && data_valid_i && snoop_req_i.cd_ready;
  assign last_beat = (beat_q == LastBeat);
  assign cr_resp   = cr_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    snoop_d = snoop_q;
    cr_d    = cr_q;
    upd_d   = upd_q;
    beat_d  = beat_q;
    case (state_q)
      StIdle: begin
        if (ac_hs) begin
          addr_d  = AddrWidth'(ac.addr);
          snoop_d = ac.snoop;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (lu_ready_i) state_d = StWaitRsp;
      end
      StWaitRsp: begin
        if (lu_rsp_valid_i) begin
          cr_d    = dec.cr_resp;
          upd_d   = dec.upd_op;
          state_d = StCr;
        end
      end
      StCr: begin
        if (snoop_req_i.cr_ready) begin
          if (cr_q[CrDataTransfer])  state_d = StCd;
          else if (upd_q != UpdNone) state_d = StUpd;
          else                       state_d = StIdle;
        end
      end
      StCd: begin
        if (cd_hs) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = (upd_q != UpdNone) ? StUpd : StIdle;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StUpd: begin
        if (upd_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
      snoop_q <= '0;
      cr_q    <= '0;
      upd_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      snoop_q <= snoop_d;
      cr_q    <= cr_d;
      upd_q   <= upd_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    cd      = '0;
    cd.data = data_i;
    cd.last = last_beat;
  end

  always_comb begin
    snoop_resp_o          = '0;
    snoop_resp_o.ac_ready = ac_ready;
    snoop_resp_o.cr_valid = (state_q == StCr);
    snoop_resp_o.cr_resp  = cr_resp;
    snoop_resp_o.cd_valid = (state_q == StCd) && data_valid_i;
    snoop_resp_o.cd       = cd;
  end

  assign lu_valid_o   = (state_q == StLookup);
  assign lu_addr_o    = addr_q;
  assign lu_snoop_o   = snoop_q;
  assign data_ready_o = (state_q == StCd) && snoop_req_i.cd_ready;
  assign upd_valid_o  = (state_q == StUpd);
  assign upd_op_o     = upd_q;

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Randomized scoreboard bench for ace_snoop_responder: a cache/interconnect model drives
// stimulus and pushes expectations; a separate monitor pops and compares on every handshake.
`timescale 1ns/1ps
module tb_ace_snoop_responder;
  import ace_pkg::*;

  localparam int NB = 4;

  logic clk, rst_n;
  ace_snoop_req_t  req;
  ace_snoop_resp_t rsp;
  logic        ac_valid, cr_ready, cd_ready;
  logic [63:0] ac_addr;
  logic [3:0]  ac_snoop;
  logic        lu_valid, lu_ready, lu_rsp_valid, lu_hit, lu_dirty, lu_shared;
  logic [63:0] lu_addr;
  logic [3:0]  lu_snoop;
  logic        data_valid, data_ready, upd_valid, upd_ready;
  logic [63:0] data;
  logic [1:0]  upd_op;

  int checks = 0;
  int errors = 0;

  logic [67:0] exp_lu_q[$];
  logic [4:0]  exp_cr_q[$];
  logic [64:0] exp_cd_q[$];
  logic [1:0]  exp_upd_q[$];
  logic [63:0] src_q[$];
  logic [2:0]  lu_res_q[$];

  int rdy_mode = 1;      // 0 random, 1 always ready, 2 cd_ready toggles
  int hold_cr = 0;
  int rsp_delay_max = 0;
  logic busy, expect_idle;

  always_comb begin
    req          = '0;
    req.ac_valid = ac_valid;
    req.ac.addr  = ac_addr;
    req.ac.snoop = ac_snoop;
    req.cr_ready = cr_ready;
    req.cd_ready = cd_ready;
  end

  ace_snoop_responder dut (
    .clk_i(clk), .rst_ni(rst_n), .snoop_req_i(req), .snoop_resp_o(rsp),
    .lu_valid_o(lu_valid), .lu_ready_i(lu_ready), .lu_addr_o(lu_addr), .lu_snoop_o(lu_snoop),
    .lu_rsp_valid_i(lu_rsp_valid), .lu_hit_i(lu_hit), .lu_dirty_i(lu_dirty), .lu_shared_i(lu_shared),
    .data_valid_i(data_valid), .data_ready_o(data_ready), .data_i(data),
    .upd_valid_o(upd_valid), .upd_ready_i(upd_ready), .upd_op_o(upd_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got a handshake expected none", name);
  endtask

  // Reference: what a snooped cache owes the interconnect, by snoop class.
  function automatic void model(input logic [3:0] sn, input logic hit, input logic dirty,
                                input logic shared, output logic [4:0] cr,
                                output logic [1:0] op, output logic xfer);
    int read_like, clean_like, keeps_copy, known, new_state;
    known = 1; read_like = 0; clean_like = 0; keeps_copy = 0; new_state = 0;
    case (sn)
      4'd0:             begin read_like = 1; keeps_copy = 1; new_state = 0; end
      4'd1, 4'd2, 4'd3: begin read_like = 1; keeps_copy = 1; new_state = 1; end
      4'd7:             begin read_like = 1; new_state = 2; end
      4'd8:             begin clean_like = 1; keeps_copy = 1; new_state = 1; end
      4'd9:             begin clean_like = 1; new_state = 2; end
      4'd13:            new_state = 2;
      default:          known = 0;
    endcase
    cr = 5'd0; op = 2'd0; xfer = 1'b0;
    if (hit && known != 0) begin
      xfer = (read_like != 0) || (clean_like != 0 && dirty);
      cr = 5'((xfer ? 1 : 0) + ((dirty && xfer && sn != 4'd0) ? 4 : 0) + keeps_copy * 8 + (shared ? 0 : 16));
      op = 2'(new_state);
    end
  endfunction

  // Ready generator
  initial begin
    lu_ready = 0; cr_ready = 0; cd_ready = 0; upd_ready = 0;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) begin
        lu_ready  = ($urandom_range(0, 2) != 0);
        cr_ready  = ($urandom_range(0, 1) != 0);
        cd_ready  = ($urandom_range(0, 2) != 0);
        upd_ready = ($urandom_range(0, 2) != 0);
      end else begin
        lu_ready  = 1'b1;
        cr_ready  = 1'b1;
        cd_ready  = (rdy_mode == 2) ? ~cd_ready : 1'b1;
        upd_ready = 1'b1;
      end
      if (hold_cr != 0) cr_ready = 1'b0;
    end
  end

  // Lookup responder; spurious result pulses whenever no lookup is outstanding
  initial begin
    logic hs, pending;
    logic [2:0] res;
    int wait_cnt;
    lu_rsp_valid = 0; lu_hit = 0; lu_dirty = 0; lu_shared = 0;
    pending = 0; res = 0; wait_cnt = 0;
    forever begin
      @(negedge clk);
      hs = rst_n && lu_valid && lu_ready;
      @(posedge clk); #1;
      if (!rst_n) pending = 0;
      if (hs && lu_res_q.size() > 0) begin
        res = lu_res_q.pop_front();
        pending = 1;
        wait_cnt = $urandom_range(0, rsp_delay_max);
      end
      if (pending) begin
        if (wait_cnt == 0) begin
          lu_rsp_valid = 1'b1;
          {lu_hit, lu_dirty, lu_shared} = res;
          pending = 0;
        end else begin
          lu_rsp_valid = 1'b0;
          wait_cnt--;
        end
      end else begin
        lu_rsp_valid = ($urandom_range(0, 3) == 0);
        {lu_hit, lu_dirty, lu_shared} = 3'($urandom_range(0, 7));
      end
    end
  end

  // Cache data source: offers the head beat, garbage when nothing is due
  initial begin
    logic take;
    data_valid = 0; data = 0;
    forever begin
      @(negedge clk);
      take = rst_n && data_valid && data_ready;
      @(posedge clk); #1;
      if (take && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        data_valid = ($urandom_range(0, 3) != 0);
        data = src_q[0];
      end else begin
        data_valid = ($urandom_range(0, 3) == 0);
        data = {$urandom, $urandom};
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic popped, lu_stall, cr_stall, upd_stall;
    logic [67:0] el, lu_prev;
    logic [64:0] ed;
    logic [4:0]  ec, cr_prev;
    logic [1:0]  eu, upd_prev;
    busy = 0; expect_idle = 0; lu_stall = 0; cr_stall = 0; upd_stall = 0;
    lu_prev = 0; cr_prev = 0; upd_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0; expect_idle = 0; lu_stall = 0; cr_stall = 0; upd_stall = 0;
      end else begin
        popped = 0;
        if (expect_idle) begin
          check("ac_ready_after_done", rsp.ac_ready, 1);
          expect_idle = 0;
        end else if (busy) begin
          check("ac_ready_while_busy", rsp.ac_ready, 0);
        end
        if (ac_valid && rsp.ac_ready) busy = 1;

        if (lu_valid) begin
          if (lu_stall) check("lu_req_stable", {lu_addr, lu_snoop}, lu_prev);
          if (lu_ready) begin
            lu_stall = 0;
            if (exp_lu_q.size() == 0) unexpected("lu_req");
            else begin
              el = exp_lu_q.pop_front();
              check("lu_addr", lu_addr, el[67:4]);
              check("lu_snoop", lu_snoop, el[3:0]);
              popped = 1;
            end
          end else begin
            lu_stall = 1; lu_prev = {lu_addr, lu_snoop};
          end
        end else lu_stall = 0;

        if (rsp.cr_valid) begin
          if (cr_stall) check("cr_resp_stable", rsp.cr_resp, cr_prev);
          if (cr_ready) begin
            cr_stall = 0;
            if (exp_cr_q.size() == 0) unexpected("cr");
            else begin
              ec = exp_cr_q.pop_front();
              check("cr_resp", rsp.cr_resp, ec);
              popped = 1;
            end
          end else begin
            cr_stall = 1; cr_prev = rsp.cr_resp;
          end
        end else cr_stall = 0;

        if (rsp.cd_valid) begin
          check("cd_data_passthru", rsp.cd.data, data);
          check("data_ready_passthru", data_ready, cd_ready);
          if (cd_ready) begin
            if (exp_cd_q.size() == 0) unexpected("cd");
            else begin
              ed = exp_cd_q.pop_front();
              check("cd_beat", {rsp.cd.data, rsp.cd.last}, ed);
              popped = 1;
            end
          end
        end

        if (upd_valid) begin
          if (upd_stall) check("upd_op_stable", upd_op, upd_prev);
          if (upd_ready) begin
            upd_stall = 0;
            if (exp_upd_q.size() == 0) unexpected("upd");
            else begin
              eu = exp_upd_q.pop_front();
              check("upd_op", upd_op, eu);
              popped = 1;
            end
          end else begin
            upd_stall = 1; upd_prev = upd_op;
          end
        end else upd_stall = 0;

        if (popped && busy && exp_lu_q.size() == 0 && exp_cr_q.size() == 0 &&
            exp_cd_q.size() == 0 && exp_upd_q.size() == 0) begin
          busy = 0;
          expect_idle = 1;
        end
      end
    end
  end

  task automatic issue(input logic [63:0] addr, input logic [3:0] sn, input logic hit,
                       input logic dirty, input logic shared);
    logic [4:0] cr;
    logic [1:0] op;
    logic xfer, got;
    logic [63:0] d;
    model(sn, hit, dirty, shared, cr, op, xfer);
    exp_lu_q.push_back({addr, sn});
    lu_res_q.push_back({hit, dirty, shared});
    exp_cr_q.push_back(cr);
    if (xfer) begin
      for (int b = 0; b < NB; b++) begin
        d = {$urandom, $urandom};
        src_q.push_back(d);
        exp_cd_q.push_back({d, (b == NB - 1)});
      end
    end
    if (op != 2'd0) exp_upd_q.push_back(op);
    ac_addr = addr; ac_snoop = sn; ac_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = rsp.ac_ready;
      @(posedge clk); #1;
    end
    ac_valid = 1'b0;
    ac_addr = {$urandom, $urandom};
    ac_snoop = 4'($urandom_range(0, 15));
    if (!got) begin
      errors++; checks++;
      $display("FAIL ac_accept_timeout: got no ac_ready expected ac_ready within 100 cycles");
    end
  endtask

  task automatic wait_done();
    logic done;
    done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(posedge clk); #1;
      done = !busy && exp_lu_q.size() == 0 && exp_cr_q.size() == 0 &&
             exp_cd_q.size() == 0 && exp_upd_q.size() == 0;
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL snoop_done_timeout: got pending work expected completion within 500 cycles");
    end
  endtask

  task automatic flush_queues();
    exp_lu_q.delete(); exp_cr_q.delete(); exp_cd_q.delete();
    exp_upd_q.delete(); src_q.delete(); lu_res_q.delete();
  endtask

  task automatic check_outputs_quiet(input string tag);
    check({tag, "_cr_valid"}, rsp.cr_valid, 0);
    check({tag, "_cd_valid"}, rsp.cd_valid, 0);
    check({tag, "_lu_valid"}, lu_valid, 0);
    check({tag, "_data_ready"}, data_ready, 0);
    check({tag, "_upd_valid"}, upd_valid, 0);
    check({tag, "_upd_op"}, upd_op, 0);
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] hold_cr_exp;
    logic [1:0] hold_op;
    logic hold_x, seen;
    int n;
    logic [3:0] ops[11];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13, 4'd4, 4'd5, 4'd15};
    ac_valid = 0; ac_addr = 0; ac_snoop = 0; rst_n = 0;

    #3;
    check("reset_ac_ready_low", rsp.ac_ready, 0);
    check_outputs_quiet("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("post_reset_ac_ready", rsp.ac_ready, 1);
    check_outputs_quiet("post_reset");
    @(posedge clk); #1;

    // Minimum AC-to-CR latency with zero-wait lookup
    rdy_mode = 1; rsp_delay_max = 0;
    issue(64'h0000_1234_5678_9ac0, SnReadShared, 1, 0, 1);
    n = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      n++;
      seen = rsp.cr_valid;
    end
    check("ac_to_cr_latency", n, 3);
    wait_done();

    issue({$urandom, $urandom}, SnReadShared, 0, 1, 0);   // miss
    wait_done();
    issue({$urandom, $urandom}, SnReadUnique, 1, 1, 0);   // dirty unique, full line
    wait_done();
    rdy_mode = 2;
    issue({$urandom, $urandom}, SnReadShared, 1, 0, 1);   // clean shared, cd_ready toggling
    wait_done();
    rdy_mode = 1;
    issue({$urandom, $urandom}, SnCleanShared, 1, 0, 1);
    wait_done();
    issue({$urandom, $urandom}, SnCleanShared, 1, 0, 0);
    wait_done();
    issue({$urandom, $urandom}, SnMakeInvalid, 1, 1, 0);
    wait_done();
    issue({$urandom, $urandom}, SnMakeInvalid, 1, 1, 1);
    wait_done();

    // CR held back for 5 cycles
    hold_cr = 1;
    model(SnReadOnce, 1, 1, 0, hold_cr_exp, hold_op, hold_x);
    issue({$urandom, $urandom}, SnReadOnce, 1, 1, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rsp.cr_valid;
    end
    for (int i = 0; i < 5; i++) begin
      check("cr_hold_valid", rsp.cr_valid, 1);
      check("cr_hold_resp", rsp.cr_resp, hold_cr_exp);
      check("cr_hold_no_ac_ready", rsp.ac_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    hold_cr = 0;
    wait_done();

    // Reset in the middle of the CD burst
    issue({$urandom, $urandom}, SnReadUnique, 1, 1, 0);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      seen = (exp_cd_q.size() <= NB - 2);
    end
    check("midcd_reached", seen, 1);
    #2 rst_n = 0;
    flush_queues();
    #1;
    check("midcd_reset_ac_ready", rsp.ac_ready, 0);
    check_outputs_quiet("midcd_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("midcd_after_ac_ready", rsp.ac_ready, 1);
    check_outputs_quiet("midcd_after");
    @(posedge clk); #1;
    issue({$urandom, $urandom}, SnReadUnique, 1, 1, 0);
    wait_done();

    // Randomized traffic
    rsp_delay_max = 3;
    for (int k = 0; k < 40; k++) begin
      rdy_mode = ($urandom_range(0, 4) == 0) ? 2 : 0;
      issue({$urandom, $urandom}, ops[$urandom_range(0, 10)], ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_done();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
